// File: rtl/bus_drvr_fifo_bank.sv
// Per-driver TX/RX FIFO bank between test agents and the bus arbiter.
// Each channel owns two FWFT FIFOs plus saturating drop and sticky error status.

module bdfb_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_vld,
    output logic         o_full,
    output logic         o_drop,
    output logic         o_udf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_empty, w_full, w_wr_ok, w_rd_ok;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL_CNT);
    // A full FIFO still takes a write when the head leaves in the same cycle;
    // an empty FIFO never serves a same-cycle read from the incoming word.
    assign w_wr_ok = i_wr & (~w_full | i_rd);
    assign w_rd_ok = i_rd & ~w_empty;
    assign o_drop  = i_wr & w_full & ~i_rd;
    assign o_udf   = i_rd & w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
            if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
    assign o_vld   = ~w_empty;
    assign o_full  = w_full;
endmodule

module bdfb_stat #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_tx_drop,
    input  logic             i_rx_drop,
    input  logic             i_udf_ev,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf,
    output logic             o_udf
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf, r_udf;
    logic [1:0]       w_inc;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_next;

    // One extra sum bit catches the carry; at most 2 is added per cycle.
    assign w_inc  = {1'b0, i_tx_drop} + {1'b0, i_rx_drop};
    assign w_sum  = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);
    assign w_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_cnt <= w_next;
            if (i_tx_drop | i_rx_drop) r_ovf <= 1'b1;
            if (i_udf_ev)              r_udf <= 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
endmodule

module bus_drvr_fifo_bank #(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cnt_w   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           tx_wr,
    input  logic [drvrs*pckg_sz-1:0]   tx_data,
    output logic [drvrs-1:0]           tx_full,
    output logic [drvrs-1:0]           pndng,
    input  logic [drvrs-1:0]           pop,
    output logic [drvrs*pckg_sz-1:0]   D_pop,
    input  logic [drvrs-1:0]           push,
    input  logic [drvrs*pckg_sz-1:0]   D_push,
    input  logic [drvrs-1:0]           rx_rd,
    output logic [drvrs*pckg_sz-1:0]   rx_data,
    output logic [drvrs-1:0]           rx_vld,
    output logic [drvrs*cnt_w-1:0]     drop_cnt,
    output logic [drvrs-1:0]           ovf,
    output logic [drvrs-1:0]           udf,
    input  logic                       clr_stat
);
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_ch
        logic w_tx_drop, w_tx_udf, w_rx_drop, w_rx_udf, w_rx_full;

        bdfb_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx (
            .clk     (clk),
            .rst_n   (reset),
            .i_wr    (tx_wr[gi]),
            .i_wdata (tx_data[gi*pckg_sz +: pckg_sz]),
            .i_rd    (pop[gi]),
            .o_rdata (D_pop[gi*pckg_sz +: pckg_sz]),
            .o_vld   (pndng[gi]),
            .o_full  (tx_full[gi]),
            .o_drop  (w_tx_drop),
            .o_udf   (w_tx_udf)
        );

        bdfb_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx (
            .clk     (clk),
            .rst_n   (reset),
            .i_wr    (push[gi]),
            .i_wdata (D_push[gi*pckg_sz +: pckg_sz]),
            .i_rd    (rx_rd[gi]),
            .o_rdata (rx_data[gi*pckg_sz +: pckg_sz]),
            .o_vld   (rx_vld[gi]),
            .o_full  (w_rx_full),
            .o_drop  (w_rx_drop),
            .o_udf   (w_rx_udf)
        );

        bdfb_stat #(.CNT_W(cnt_w)) u_stat (
            .clk       (clk),
            .rst_n     (reset),
            .i_clr     (clr_stat),
            .i_tx_drop (w_tx_drop),
            .i_rx_drop (w_rx_drop),
            .i_udf_ev  (w_tx_udf | w_rx_udf),
            .o_cnt     (drop_cnt[gi*cnt_w +: cnt_w]),
            .o_ovf     (ovf[gi]),
            .o_udf     (udf[gi])
        );
    end
endmodule

// File: tb/tb_bus_drvr_fifo_bank.sv
// Scoreboard bench for bus_drvr_fifo_bank: stimulus queues expectations,
// a negedge monitor compares them against the DUT.

module tb_bus_drvr_fifo_bank;
    localparam int N = 4, PW = 16, DEP = 8, CW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      tx_wr = '0, pop = '0, push = '0, rx_rd = '0;
    logic [N*PW-1:0]   tx_data = '0, D_push = '0;
    logic              clr_stat = 1'b0;
    logic [N-1:0]      tx_full, pndng, rx_vld, ovf, udf;
    logic [N*PW-1:0]   D_pop, rx_data;
    logic [N*CW-1:0]   drop_cnt;

    always #5 clk = ~clk;

    bus_drvr_fifo_bank #(.drvrs(N), .pckg_sz(PW), .depth(DEP), .cnt_w(CW)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .pndng(pndng), .pop(pop), .D_pop(D_pop), .push(push), .D_push(D_push),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_vld(rx_vld), .drop_cnt(drop_cnt),
        .ovf(ovf), .udf(udf), .clr_stat(clr_stat)
    );

    typedef enum int {K_PNDNG, K_FULL, K_RXVLD, K_DROP, K_OVF, K_UDF, K_DPOP, K_RXD} kind_e;
    typedef struct {
        kind_e       k;
        int          ch;
        logic [31:0] exp;
    } chk_t;

    chk_t          st_q[$];
    logic [PW-1:0] tx_q[N][$];
    logic [PW-1:0] rx_q[N][$];
    int            n_cmp = 0, n_err = 0;

    task automatic cmp(string nm, int ch, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %h, want %h", nm, ch, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(kind_e k, int ch);
        case (k)
            K_PNDNG: return 32'(pndng[ch]);
            K_FULL:  return 32'(tx_full[ch]);
            K_RXVLD: return 32'(rx_vld[ch]);
            K_DROP:  return 32'(drop_cnt[ch*CW +: CW]);
            K_OVF:   return 32'(ovf[ch]);
            K_UDF:   return 32'(udf[ch]);
            K_DPOP:  return 32'(D_pop[ch*PW +: PW]);
            default: return 32'(rx_data[ch*PW +: PW]);
        endcase
    endfunction

    // Monitor: outputs are registered, so at negedge they reflect the last edge,
    // and the strobes seen here are the ones the next edge will act on.
    always @(negedge clk) begin
        chk_t c;
        while (st_q.size() > 0) begin
            c = st_q.pop_front();
            cmp(c.k.name(), c.ch, act_of(c.k, c.ch), c.exp);
        end
        for (int i = 0; i < N; i++) begin
            if (reset && pop[i] && pndng[i]) begin
                if (tx_q[i].size() == 0) cmp("D_pop_unexpected", i, 32'(D_pop[i*PW +: PW]), 32'hFFFF_FFFF);
                else cmp("D_pop", i, 32'(D_pop[i*PW +: PW]), 32'(tx_q[i].pop_front()));
            end
            if (reset && rx_rd[i] && rx_vld[i]) begin
                if (rx_q[i].size() == 0) cmp("rx_data_unexpected", i, 32'(rx_data[i*PW +: PW]), 32'hFFFF_FFFF);
                else cmp("rx_data", i, 32'(rx_data[i*PW +: PW]), 32'(rx_q[i].pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tx_wr = '0; pop = '0; push = '0; rx_rd = '0; clr_stat = 1'b0;
    endtask

    task automatic ex(kind_e k, int ch, logic [31:0] v);
        chk_t c;
        c.k = k; c.ch = ch; c.exp = v;
        st_q.push_back(c);
    endtask

    task automatic wr_tx(int ch, logic [PW-1:0] d, bit acc);
        tx_wr[ch] = 1'b1;
        tx_data[ch*PW +: PW] = d;
        if (acc) tx_q[ch].push_back(d);
    endtask

    task automatic wr_rx(int ch, logic [PW-1:0] d, bit acc);
        push[ch] = 1'b1;
        D_push[ch*PW +: PW] = d;
        if (acc) rx_q[ch].push_back(d);
    endtask

    initial begin
        logic [PW-1:0] d;

        // reset / idle
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            ex(K_PNDNG, i, 0); ex(K_RXVLD, i, 0); ex(K_FULL, i, 0);
            ex(K_DROP, i, 0);  ex(K_DPOP, i, 0);
        end

        // ch2 fill / drain ordering
        for (int k = 1; k <= 8; k++) begin
            wr_tx(2, PW'(k), 1'b1);
            if (k == 1) ex(K_PNDNG, 2, 0);
            step();
            if (k == 1) ex(K_PNDNG, 2, 1);
            if (k == 7) ex(K_FULL, 2, 0);
            if (k == 8) ex(K_FULL, 2, 1);
        end
        for (int k = 0; k < 8; k++) begin pop[2] = 1'b1; step(); end
        ex(K_PNDNG, 2, 0); ex(K_FULL, 2, 0);

        // ch0 overflow, then write accepted alongside a pop while full
        for (int k = 1; k <= 8; k++) begin wr_tx(0, 16'h00A0 + PW'(k), 1'b1); step(); end
        for (int k = 1; k <= 3; k++) begin wr_tx(0, 16'hBAD0 + PW'(k), 1'b0); step(); end
        ex(K_DROP, 0, 3); ex(K_OVF, 0, 1); ex(K_FULL, 0, 1); ex(K_UDF, 0, 0);
        wr_tx(0, 16'hC000, 1'b1); pop[0] = 1'b1; step();
        ex(K_DROP, 0, 3); ex(K_FULL, 0, 1); ex(K_DPOP, 0, 32'h00A2);
        for (int k = 0; k < 8; k++) begin pop[0] = 1'b1; step(); end
        ex(K_PNDNG, 0, 0);

        // ch0 simultaneous TX+RX drops add 2, then saturate
        for (int k = 1; k <= 8; k++) begin
            wr_tx(0, 16'hD000 + PW'(k), 1'b1); wr_rx(0, 16'hE000 + PW'(k), 1'b1); step();
        end
        ex(K_FULL, 0, 1); ex(K_RXVLD, 0, 1);
        wr_tx(0, 16'hFFFF, 1'b0); wr_rx(0, 16'hFFFF, 1'b0); step();
        ex(K_DROP, 0, 5);
        repeat (130) begin wr_tx(0, 16'hFFFF, 1'b0); wr_rx(0, 16'hFFFF, 1'b0); step(); end
        ex(K_DROP, 0, 255); ex(K_OVF, 0, 1); ex(K_OVF, 1, 0);
        for (int k = 0; k < 8; k++) begin pop[0] = 1'b1; rx_rd[0] = 1'b1; step(); end
        ex(K_PNDNG, 0, 0); ex(K_RXVLD, 0, 0);

        // ch1 underflow, pointers intact, clear wins over a same-cycle event
        pop[1] = 1'b1; step();
        ex(K_UDF, 1, 1); ex(K_UDF, 0, 0); ex(K_PNDNG, 1, 0);
        wr_tx(1, 16'h1111, 1'b1); step();
        ex(K_DPOP, 1, 32'h1111);
        pop[1] = 1'b1; step();
        ex(K_PNDNG, 1, 0);
        clr_stat = 1'b1; pop[1] = 1'b1; step();
        for (int i = 0; i < N; i++) begin ex(K_UDF, i, 0); ex(K_OVF, i, 0); ex(K_DROP, i, 0); end

        // ch3 wrap-around with occupancy between 3 and 6
        d = 16'h3000;
        for (int k = 0; k < 3; k++) begin wr_tx(3, d, 1'b1); d++; step(); end
        for (int g = 0; g < 7; g++) begin
            for (int k = 0; k < 3; k++) begin wr_tx(3, d, 1'b1); d++; step(); end
            ex(K_FULL, 3, 0); ex(K_PNDNG, 3, 1);
            for (int k = 0; k < 3; k++) begin pop[3] = 1'b1; step(); end
        end
        for (int k = 0; k < 3; k++) begin pop[3] = 1'b1; step(); end
        ex(K_PNDNG, 3, 0);

        // ch1 RX path, then reset with 3 entries pending
        for (int k = 1; k <= 5; k++) begin wr_rx(1, 16'h5000 + PW'(k), 1'b1); step(); end
        ex(K_RXVLD, 1, 1);
        for (int k = 0; k < 2; k++) begin rx_rd[1] = 1'b1; step(); end
        ex(K_RXVLD, 1, 1); ex(K_RXD, 1, 32'h5003);
        step();
        reset = 1'b0;
        rx_q[1].delete();
        ex(K_RXVLD, 1, 0); ex(K_RXD, 1, 0);
        step(); step();
        reset = 1'b1;
        step();
        ex(K_RXVLD, 1, 0); ex(K_PNDNG, 1, 0);
        step();

        @(negedge clk); #1;
        for (int i = 0; i < N; i++) begin
            cmp("tx_left", i, 32'(tx_q[i].size()), 0);
            cmp("rx_left", i, 32'(rx_q[i].size()), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: time limit reached, want stimulus complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "bench timed out");
    end
endmodule
